regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor of the core's 2R1W general-purpose register file.
- Configurable width, depth and read-port count.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Post-reset clear sweep, so no register ever reads as X.
- Per-register pending scoreboard, so the decode stage can detect RAW hazards against in-flight writebacks.
- Sits between decode (read and reserve ports) and writeback (write port).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers (>=2)
NREAD, 2, number of read ports (>=1)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes, and is never pending
BYPASS, 1, 1: same-cycle write data and pending-clear are forwarded to the read ports
(derived, localparam) AW = $clog2(NREGS)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
ready  out  1  high once the clear sweep is done; writes and reserves are accepted only when high
raddr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NREAD*XLEN  read data, combinational, port i at [i*XLEN +: XLEN]
rpend  out  NREAD  pending bit of the addressed register, per port, combinational
we  in  1  write enable
waddr  in  AW  write address
wdata  in  XLEN  write data
rsv_valid  in  1  reserve request: mark register rsv_addr pending
rsv_addr  in  AW  register to reserve

Behaviour:
- State machine has two states, CLEAR and RUN.
- Reset:
  - Any posedge with rst_n=0 sets state=CLEAR, clr_idx=0 and all pending bits=0.
  - ready=0 in that cycle and afterwards, until the sweep completes.
  - Reset mid-sweep or mid-RUN restarts the sweep from index 0.
- CLEAR state:
  - Each posedge with rst_n=1 writes mem[clr_idx]=0 and increments clr_idx.
  - The posedge that clears index NREGS-1 moves to RUN.
  - ready=1 therefore rises exactly NREGS posedges after the first posedge with rst_n=1.
  - While in CLEAR: we and rsv_valid are ignored, all rdata=0, all rpend=0.
- RUN state, write:
  - A write is valid when we=1, waddr<NREGS, and !(ZERO_REG && waddr==0).
  - On the posedge, mem[waddr]<=wdata and pend[waddr]<=0.
- RUN state, reserve:
  - A reserve is valid when rsv_valid=1, rsv_addr<NREGS, and !(ZERO_REG && rsv_addr==0).
  - On the posedge, pend[rsv_addr]<=1.
  - A valid reserve and a valid write to the same register in one cycle: the data is written and the pending bit ends at 1 (reserve wins).
- Read port i, priority order:
  1. ZERO_REG && raddr_i==0: rdata=0, rpend=0.
  2. raddr_i>=NREGS: rdata=0, rpend=0.
  3. BYPASS && valid write && waddr==raddr_i: rdata=wdata, rpend=0.
  4. Otherwise: rdata=mem[raddr_i], rpend=pend[raddr_i].
- Bypass off: with BYPASS=0, written data and the pending clear become visible the cycle after the write.
- Read/reserve interaction: rpend never reflects a same-cycle reserve. The reserve becomes visible the next cycle.
- Port independence: all read ports operate independently; several ports reading the same address return identical values.
- Latency: reads are 0-cycle (combinational); writes and reserves take effect at the next posedge.
- Non-power-of-two NREGS: addresses >=NREGS are handled as in read-port rule 2; writes and reserves to them are dropped.

Decomposition:
- Package regfile_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - default XLEN/NREGS constants shared with decode and writeback.
- Sub-module regfile_scoreboard owns:
  - the NREGS pending-bit vector, set-on-reserve / clear-on-write with set priority;
  - the NREAD lookup outputs, taking ready as a qualifier.
- Data array, clear FSM and bypass muxing stay in regfile_mp.

Test Plan:
- Defaults; hold rst_n=0 3 cycles, release -> ready=0 for 32 posedges, then 1. Before and after ready rises, every address reads 0 and rpend=0; we=1 waddr=5 during the sweep is dropped (reads 0 after ready).
- RUN; write waddr=0 wdata=0xDEADBEEF -> raddr=0 still reads 0. Write waddr=7 wdata=0x12345678 -> same-cycle rdata=0x12345678 (BYPASS=1); with BYPASS=0 the old value shows, the new value one cycle later.
- rsv_valid addr=9 -> rpend=1 from the next cycle. Write addr 9 with 0xA5A5A5A5 -> rpend=0 in the same cycle (BYPASS=1) and afterwards. Reserve plus write to addr 9 in one cycle -> data updated, rpend=1 next cycle.
- NREAD=4; all four ports read addr 3 after writing 0x33 -> all rdata=0x33; ports on addr 0, 1 and 31 concurrently return their independent values.
- NREGS=24, AW=5; write/reserve addr 30 -> ignored; read addr 30 -> rdata=0, rpend=0. Sweep completes in exactly 24 cycles.
- Mid-RUN with pend[4]=1 and mem[4]=0x44: assert rst_n=0 for 1 cycle -> ready drops, pend cleared, sweep restarts, mem[4]=0 after ready rises.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the clear/run state encoding and the default geometry that decode
// and writeback also use, so all three agree on XLEN and register count.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW hazard detection at decode.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears every bit)
//   ready        register file is out of its clear sweep; lookups read 0 otherwise
//   set_en/addr  qualified reserve: mark a register pending
//   clr_en/addr  qualified write: mark a register no longer pending
//   raddr        NREAD packed read addresses
//   rok          per-port "address names a real, non-hardwired register"
//   lpend        per-port pending bit of the addressed register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ready,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic [NREAD*AW-1:0] raddr,
  input  logic [NREAD-1:0]    rok,
  output logic [NREAD-1:0]    lpend
);

  logic [NREGS-1:0] pend;

  // Set is applied after clear so a reserve and a write to the same
  // register in one cycle leave it pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (clr_en) pend[clr_addr] <= 1'b0;
      if (set_en) pend[set_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_lk
    assign lpend[i] = ready && rok[i] && pend[raddr[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read, single-write register file with a post-reset
// clear sweep, optional hardwired-zero register 0, optional write-to-read
// bypass and a per-register pending scoreboard.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ready               clear sweep complete; writes/reserves accepted only when high
//   raddr/rdata/rpend   NREAD combinational read ports (packed, port i at slice i)
//   we/waddr/wdata      writeback port
//   rsv_valid/rsv_addr  decode reservation of a destination register
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int   XLEN     = DEF_XLEN,
  parameter int   NREGS    = DEF_NREGS,
  parameter int   NREAD    = 2,
  parameter bit   ZERO_REG = 1'b1,
  parameter bit   BYPASS   = 1'b1,
  localparam int  AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rpend,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  rsv_valid,
  input  logic [AW-1:0]         rsv_addr
);

  // Address names a real register that can hold state.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !(ZERO_REG && (a == '0));
  endfunction

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_ok, rsv_ok;
  logic [NREAD-1:0] rok, byp, sb_pend;

  assign wr_ok  = ready && we && addr_ok(waddr);
  assign rsv_ok = ready && rsv_valid && addr_ok(rsv_addr);

  // Clear FSM; ready is registered and rises with the move to RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (32'(clr_idx) == NREGS - 1) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: ;
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Data array has no reset of its own; the sweep zeroes it after reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) mem[clr_idx] <= '0;
      else if (wr_ok)        mem[waddr]   <= wdata;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .set_en   (rsv_ok),
    .set_addr (rsv_addr),
    .clr_en   (wr_ok),
    .clr_addr (waddr),
    .raddr    (raddr),
    .rok      (rok),
    .lpend    (sb_pend)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a      = raddr[i*AW +: AW];
    assign rok[i] = addr_ok(a);
    // Forwarding only ever sees qualified writes, so reg 0 and
    // out-of-range addresses never pick up wdata.
    assign byp[i] = BYPASS && wr_ok && (waddr == a);
    assign rdata[i*XLEN +: XLEN] = (!ready || !rok[i]) ? '0 :
                                   byp[i]              ? wdata : mem[a];
    // A bypassed write is also clearing the pending bit this cycle.
    assign rpend[i] = sb_pend[i] && !byp[i];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: stimulus pushes expected read results tagged with the
// current cycle; a negedge monitor pops and compares against the DUT.
// DUT A: defaults with NREAD=4. DUT B: NREGS=24, NREAD=2, BYPASS=0.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [19:0]  raddr_a;
  logic [127:0] rdata_a;
  logic [3:0]   rpend_a;
  logic         ready_a, we_a, rsv_a;
  logic [4:0]   waddr_a, rsv_addr_a;
  logic [31:0]  wdata_a;

  logic [9:0]   raddr_b;
  logic [63:0]  rdata_b;
  logic [1:0]   rpend_b;
  logic         ready_b, we_b, rsv_b;
  logic [4:0]   waddr_b, rsv_addr_b;
  logic [31:0]  wdata_b;

  regfile_mp #(.NREAD(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ready(ready_a),
    .raddr(raddr_a), .rdata(rdata_a), .rpend(rpend_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .rsv_valid(rsv_a), .rsv_addr(rsv_addr_a)
  );

  regfile_mp #(.NREGS(24), .NREAD(2), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b),
    .raddr(raddr_b), .rdata(rdata_b), .rpend(rpend_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .rsv_valid(rsv_b), .rsv_addr(rsv_addr_b)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          port;
    logic [31:0] data;
    logic        pend;
    logic        rdy;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] d;
    logic p, r;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        d = rdata_a[e.port*32 +: 32]; p = rpend_a[e.port]; r = ready_a;
      end else begin
        d = rdata_b[e.port*32 +: 32]; p = rpend_b[e.port]; r = ready_b;
      end
      n_chk++;
      if (e.cyc != cyc || d !== e.data || p !== e.pend || r !== e.rdy) begin
        n_fail++;
        $display("FAIL %s (cyc %0d dut%0d port%0d): got data=%h pend=%b ready=%b, need data=%h pend=%b ready=%b",
                 e.name, e.cyc, e.dut, e.port, d, p, r, e.data, e.pend, e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; rsv_a = 1'b0; we_b = 1'b0; rsv_b = 1'b0;
  endtask

  // Drive one read address and queue the response expected this cycle.
  task automatic rd(input int dut, input int port, input int addr,
                    input logic [31:0] d, input logic p, input logic r, input string nm);
    if (dut == 0) raddr_a[port*5 +: 5] = 5'(addr);
    else          raddr_b[port*5 +: 5] = 5'(addr);
    q.push_back('{cyc, dut, port, d, p, r, nm});
  endtask

  initial begin
    rst_n = 1'b0;
    raddr_a = '0; raddr_b = '0;
    waddr_a = '0; wdata_a = '0; rsv_addr_a = '0;
    waddr_b = '0; wdata_b = '0; rsv_addr_b = '0;
    idle();

    for (int k = 0; k < 3; k++) begin
      tick();
      rd(0, 0, 0, 0, 0, 0, "rst_a");
      rd(1, 0, 0, 0, 0, 0, "rst_b");
    end
    rst_n = 1'b1;

    // Sweep: writes to reg 5 during CLEAR must be dropped.
    for (int k = 1; k <= 32; k++) begin
      tick();
      we_a = (k < 32); waddr_a = 5'd5; wdata_a = 32'hFFFF_FFFF;
      rd(0, 0, 5, 0, 0, k == 32, "sweep_a");
      rd(0, 1, k % 32, 0, 0, k == 32, "sweep_a_any");
      rd(1, 0, 0, 0, 0, k >= 24, "sweep_b");
    end
    idle();
    for (int a = 0; a < 32; a += 4) begin
      tick();
      for (int p = 0; p < 4; p++) rd(0, p, a + p, 0, 0, 1, "all_zero");
    end

    tick(); we_a = 1; waddr_a = 0; wdata_a = 32'hDEAD_BEEF;
    rd(0, 0, 0, 0, 0, 1, "zero_wr");
    tick(); idle(); rd(0, 0, 0, 0, 0, 1, "zero_rd");
    tick(); we_a = 1; waddr_a = 7; wdata_a = 32'h1234_5678;
    rd(0, 0, 7, 32'h1234_5678, 0, 1, "byp7");
    tick(); idle(); rd(0, 0, 7, 32'h1234_5678, 0, 1, "rd7");
    tick(); rsv_a = 1; rsv_addr_a = 9;
    rd(0, 0, 9, 0, 0, 1, "rsv_same");
    tick(); idle(); rd(0, 0, 9, 0, 1, 1, "rsv_next");
    tick(); we_a = 1; waddr_a = 9; wdata_a = 32'hA5A5_A5A5;
    rd(0, 0, 9, 32'hA5A5_A5A5, 0, 1, "wr_clr_byp");
    tick(); idle(); rd(0, 0, 9, 32'hA5A5_A5A5, 0, 1, "wr_clr");
    tick(); we_a = 1; waddr_a = 9; wdata_a = 32'h1111_2222; rsv_a = 1; rsv_addr_a = 9;
    rd(0, 0, 9, 32'h1111_2222, 0, 1, "rsv_wr_same");
    tick(); idle(); rd(0, 0, 9, 32'h1111_2222, 1, 1, "rsv_wins");
    tick(); we_a = 1; waddr_a = 3; wdata_a = 32'h33;
    for (int p = 0; p < 4; p++) rd(0, p, 3, 32'h33, 0, 1, "multi_byp3");
    tick(); idle();
    for (int p = 0; p < 4; p++) rd(0, p, 3, 32'h33, 0, 1, "multi_rd3");
    tick(); we_a = 1; waddr_a = 1; wdata_a = 32'h0101_0101; rsv_a = 1; rsv_addr_a = 31;
    tick(); idle();
    rd(0, 0, 0, 0, 0, 1, "indep_p0");
    rd(0, 1, 1, 32'h0101_0101, 0, 1, "indep_p1");
    rd(0, 2, 31, 0, 1, 1, "indep_p2");
    rd(0, 3, 9, 32'h1111_2222, 1, 1, "indep_p3");

    // Mid-RUN reset with reg 4 written and pending.
    tick(); we_a = 1; waddr_a = 4; wdata_a = 32'h44; rsv_a = 1; rsv_addr_a = 4;
    rd(0, 0, 4, 32'h44, 0, 1, "pre_rst_byp");
    tick(); idle(); rst_n = 1'b0;
    rd(0, 0, 4, 32'h44, 1, 1, "pre_rst");
    tick(); rst_n = 1'b1;
    rd(0, 0, 4, 0, 0, 0, "rst_drop4");
    rd(0, 1, 9, 0, 0, 0, "rst_drop9");
    rd(1, 0, 3, 0, 0, 0, "rst_drop_b");
    for (int k = 1; k <= 32; k++) begin
      tick();
      rd(0, 0, 4, 0, 0, k == 32, "resweep4");
      rd(0, 1, 9, 0, 0, k == 32, "resweep9");
      rd(1, 0, 3, 0, 0, k >= 24, "resweep_b");
    end

    // DUT B: no bypass, 24 registers.
    tick(); we_b = 1; waddr_b = 7; wdata_b = 32'h1234_5678;
    rd(1, 0, 7, 0, 0, 1, "nobyp_old");
    tick(); idle(); rd(1, 0, 7, 32'h1234_5678, 0, 1, "nobyp_new");
    tick(); we_b = 1; waddr_b = 30; wdata_b = 32'hFFFF_FFFF; rsv_b = 1; rsv_addr_b = 30;
    rd(1, 0, 30, 0, 0, 1, "oor_same");
    rd(1, 1, 6, 0, 0, 1, "oor_alias_same");
    tick(); idle();
    rd(1, 0, 30, 0, 0, 1, "oor_after");
    rd(1, 1, 6, 0, 0, 1, "oor_alias");
    tick(); we_b = 1; waddr_b = 23; wdata_b = 32'h23; rsv_b = 1; rsv_addr_b = 5;
    rd(1, 0, 5, 0, 0, 1, "rsv_b_same");
    rd(1, 1, 23, 0, 0, 1, "top_b_old");
    tick(); idle();
    rd(1, 0, 23, 32'h23, 0, 1, "top_b_new");
    rd(1, 1, 5, 0, 1, 1, "rsv_b_next");
    tick(); we_b = 1; waddr_b = 5; wdata_b = 32'h55;
    rd(1, 1, 5, 0, 1, 1, "nobyp_pend_old");
    tick(); idle(); rd(1, 1, 5, 32'h55, 0, 1, "nobyp_pend_new");

    tick(); tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left, need 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
